samples_buffer: RTL



---
 rtl/samples_pkg.sv | 38 +++
 rtl/line_fifo.sv | 77 +++++++
 rtl/samples_buffer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/samples_pkg.sv
// samples_pkg: shared helpers for the samples buffer.
//   samples_per_line(dw, sw) : number of samples packed into one line
//   lane_width(spl)          : width of the lane counter
//   level_width(depth)       : width of a 0..depth line counter
//   CTI_* / BTE_*            : Wishbone cycle-type / burst-type encodings. They are
//                              listed for reference only, because the bus logic
//                              ignores both fields.
//   wb_state_e               : bus handshake state.
package samples_pkg;

    localparam logic [2:0] CTI_CLASSIC   = 3'b000;
    localparam logic [2:0] CTI_CONST     = 3'b001;
    localparam logic [2:0] CTI_INCR      = 3'b010;
    localparam logic [2:0] CTI_END       = 3'b111;

    localparam logic [1:0] BTE_LINEAR    = 2'b00;
    localparam logic [1:0] BTE_WRAP4     = 2'b01;
    localparam logic [1:0] BTE_WRAP8     = 2'b10;
    localparam logic [1:0] BTE_WRAP16    = 2'b11;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_e;

    function automatic int samples_per_line(input int dw, input int sw);
        return dw / sw;
    endfunction

    function automatic int lane_width(input int spl);
        return (spl > 1) ? $clog2(spl) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/line_fifo.sv
// line_fifo: synchronous DEPTH x DW line FIFO.
// The head read is registered: head_o loads the popped line at the pop edge and
// keeps that value until the next pop.
//   clk, rst     : clock and synchronous active-high reset
//   flush_i      : empties the FIFO. Push and pop are ignored in the same cycle.
//   push_i       : write push_data_i. Ignored when the FIFO is full unless a pop
//                  happens in the same cycle.
//   pop_i        : pop the head into head_o. Ignored when the FIFO is empty.
//   head_o       : registered copy of the last popped line
//   full_o, empty_o, count_o : occupancy
module line_fifo #(
    parameter int DW    = 256,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [DW-1:0]    push_data_i,
    input  logic             pop_i,
    output logic [DW-1:0]    head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [DW-1:0]    head_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = head_q;

    // When the FIFO is full, a push and a pop in the same cycle share a slot. The
    // pop reads the old contents before the write lands.
    assign do_pop  = pop_i && !flush_i && !empty_o;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                head_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/samples_buffer.sv
// samples_buffer: packs a narrow sample stream into lines and serves them to a
// Wishbone master. Each read returns one line and pops it from the FIFO.
//   clk, rst                       : clock and synchronous active-high reset
//   flush_i                        : drops all queued lines and the partial line
//   sample_valid_i/data_i/ready_o  : input sample stream
//   samples_cyc/stb/we_i, ack_o    : Wishbone handshake. Writes are acked and
//                                    their data is discarded.
//   samples_addr/mosi/cti/bte_i    : ignored
//   samples_miso_o                 : last popped line, valid while ack_o is high
//   level_o                        : number of complete lines queued
//   lane_o                         : number of samples held in the partial line
//
// Wishbone handshake states:
//   state   | meaning
//   WB_IDLE | waiting for a request that can be accepted
//   WB_ACK  | ack_o is high for one cycle; no new request is accepted here
module samples_buffer
    import samples_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 32,
    parameter int DEPTH        = 16,
    localparam int SPL     = samples_per_line(DATA_WIDTH, SAMPLE_WIDTH),
    localparam int LANE_W  = lane_width(SPL),
    localparam int LEVEL_W = level_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    sample_valid_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_data_i,
    output logic                    sample_ready_o,
    input  logic                    samples_cyc_i,
    input  logic                    samples_stb_i,
    input  logic                    samples_we_i,
    output logic                    samples_ack_o,
    input  logic [ADDR_WIDTH-1:0]   samples_addr_i,
    input  logic [DATA_WIDTH-1:0]   samples_mosi_i,
    output logic [DATA_WIDTH-1:0]   samples_miso_o,
    input  logic [2:0]              samples_cti_i,
    input  logic [1:0]              samples_bte_i,
    output logic [LEVEL_W-1:0]      level_o,
    output logic [LANE_W-1:0]       lane_o
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SPL - 1);

    wb_state_e              state_q, state_d;
    logic [LANE_W-1:0]      lane_q;
    logic [DATA_WIDTH-1:0]  partial_q;
    logic [DATA_WIDTH-1:0]  line_d;
    logic                   xfer, push, accept, pop;
    logic                   fifo_full, fifo_empty;

    logic unused_inputs;
    assign unused_inputs = ^{samples_addr_i, samples_mosi_i, samples_cti_i, samples_bte_i};

    // Ready depends only on registered state and flush_i. It ignores a pop in the
    // same cycle, so a full FIFO refuses the closing sample until one cycle after
    // the pop.
    assign sample_ready_o = !(fifo_full && lane_q == LAST_LANE) && !flush_i;
    assign xfer           = sample_valid_i && sample_ready_o;
    assign push           = xfer && (lane_q == LAST_LANE);

    always_comb begin
        line_d = partial_q;
        line_d[DATA_WIDTH-SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q    <= '0;
            partial_q <= '0;
        end else if (flush_i) begin
            lane_q    <= '0;
        end else if (xfer) begin
            partial_q[lane_q*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= sample_data_i;
            lane_q <= (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (samples_cyc_i && samples_stb_i && !flush_i &&
                    (samples_we_i || !fifo_empty)) begin
                    accept  = 1'b1;
                    state_d = WB_ACK;
                end
            end
            WB_ACK:  state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    assign pop           = accept && !samples_we_i;
    assign samples_ack_o = (state_q == WB_ACK);
    assign lane_o        = lane_q;

    line_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_line_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .push_i      (push),
        .push_data_i (line_d),
        .pop_i       (pop),
        .head_o      (samples_miso_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (level_o)
    );

endmodule
